// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and sizes for the voice allocator and noteCore array
package music_pkg;

    localparam int NUM_TRACKS  = 2;
    localparam int PACKET_SIZE = 24;

    typedef logic [PACKET_SIZE-1:0] packetType;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } voiceState_t;

    typedef struct packed {
        logic        noteOn;
        logic [15:0] tuneWord;
        logic [7:0]  volume;
    } noteEvent_t;

endpackage

// File: rtl/voice_envelope.sv
// rtl/voice_envelope.sv - one voice: state, tune word and linear attack/release volume ramp
module voice_envelope
    import music_pkg::*;
#(
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   cmd_load,
    input  logic                   cmd_retrig,
    input  logic                   cmd_release,
    input  logic [15:0]            cmd_tune,
    input  logic [7:0]             cmd_target,
    output logic [1:0]             state_o,
    output logic [PACKET_SIZE-1:0] packet_o
);

    localparam logic [8:0] A_STEP = 9'(ATTACK_STEP);
    localparam logic [8:0] R_STEP = 9'(RELEASE_STEP);

    voiceState_t state_q, state_d;
    logic [15:0] tune_q, tune_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  vol_q, vol_d;
    logic [8:0]  up_sum, down_sum, rel_sum, over;

    always_comb begin
        state_d  = state_q;
        tune_d   = tune_q;
        target_d = target_q;
        vol_d    = vol_q;
        up_sum   = {1'b0, vol_q} + A_STEP;
        down_sum = {1'b0, vol_q} - A_STEP;
        rel_sum  = {1'b0, vol_q} - R_STEP;
        over     = {1'b0, vol_q} - {1'b0, target_q};

        // an event on this voice takes priority and the voice skips any coincident tick
        if (cmd_load) begin
            tune_d   = cmd_tune;
            target_d = cmd_target;
            vol_d    = 8'd0;
            state_d  = ATTACK;
        end else if (cmd_retrig) begin
            target_d = cmd_target;
            state_d  = ATTACK;
        end else if (cmd_release) begin
            state_d  = RELEASE;
        end else if (tick) begin
            case (state_q)
                ATTACK: begin
                    if (vol_q < target_q) begin
                        if (up_sum >= {1'b0, target_q}) begin
                            vol_d   = target_q;
                            state_d = SUSTAIN;
                        end else begin
                            vol_d = up_sum[7:0];
                        end
                    end else if (vol_q > target_q) begin
                        if (over <= A_STEP) begin
                            vol_d   = target_q;
                            state_d = SUSTAIN;
                        end else begin
                            vol_d = down_sum[7:0];
                        end
                    end else begin
                        state_d = SUSTAIN;
                    end
                end
                RELEASE: begin
                    if ({1'b0, vol_q} <= R_STEP) begin
                        vol_d    = 8'd0;
                        tune_d   = 16'd0;
                        target_d = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        vol_d = rel_sum[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tune_q   <= 16'd0;
            target_q <= 8'd0;
            vol_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            tune_q   <= tune_d;
            target_q <= target_d;
            vol_q    <= vol_d;
        end
    end

    assign state_o  = state_q;
    assign packet_o = (state_q == IDLE) ? '0 : {tune_q, vol_q};

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note event scheduler with oldest-voice stealing
module voice_allocator
    import music_pkg::PACKET_SIZE, music_pkg::voiceState_t, music_pkg::noteEvent_t,
           music_pkg::IDLE, music_pkg::ATTACK, music_pkg::SUSTAIN;
#(
    parameter int NUM_TRACKS   = 2,
    parameter int RAMP_DIV     = 256,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              evValid,
    output logic                              evReady,
    input  logic                              evNoteOn,
    input  logic [15:0]                       evTuneWord,
    input  logic [7:0]                        evVolume,
    output logic [NUM_TRACKS*PACKET_SIZE-1:0] notePackets,
    output logic [NUM_TRACKS-1:0]             voiceBusy,
    output logic                              stealPulse
);

    localparam int AGE_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int CNT_W = $clog2(RAMP_DIV);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_TRACKS - 1);

    typedef enum logic {
        EV_ACCEPT  = 1'b0,
        EV_PROCESS = 1'b1
    } evState_t;

    evState_t         ev_state_q, ev_state_d;
    logic             ev_ready_q, ev_ready_d;
    noteEvent_t       ev_q, ev_d;
    logic             steal_q, steal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AGE_W-1:0] age_q [NUM_TRACKS];
    logic [AGE_W-1:0] age_d [NUM_TRACKS];

    logic                  tick;
    logic                  note_on;
    logic [15:0]           ev_tune;
    logic [7:0]            ev_vol;
    logic [AGE_W-1:0]      old_age;
    logic [NUM_TRACKS-1:0] v_busy, hit_oh, idle_oh, rel_oh, old_oh, sel_oh;
    logic [NUM_TRACKS-1:0] cmd_load, cmd_retrig, cmd_release;
    logic [2*NUM_TRACKS-1:0] state_flat;
    voiceState_t           v_state [NUM_TRACKS];
    logic [15:0]           v_tune  [NUM_TRACKS];

    assign tick    = (cnt_q == CNT_W'(RAMP_DIV - 1));
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign ev_tune = ev_q.tuneWord;
    assign ev_vol  = ev_q.volume;
    assign note_on = ev_q.noteOn && (ev_q.volume != 8'd0);

    // per-voice candidates: retrigger hit, free voice, note-off target, oldest voice
    always_comb begin
        hit_oh  = '0;
        idle_oh = '0;
        rel_oh  = '0;
        old_oh  = '0;
        old_age = '0;
        v_busy  = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            v_state[i] = voiceState_t'(state_flat[2*i +: 2]);
            v_tune[i]  = notePackets[PACKET_SIZE*i + 8 +: 16];
            v_busy[i]  = (v_state[i] != IDLE);
            if (v_busy[i] && v_tune[i] == ev_tune && hit_oh == '0)
                hit_oh[i] = 1'b1;
            if (!v_busy[i] && idle_oh == '0)
                idle_oh[i] = 1'b1;
            if ((v_state[i] == ATTACK || v_state[i] == SUSTAIN) && v_tune[i] == ev_tune
                && rel_oh == '0)
                rel_oh[i] = 1'b1;
            if (old_oh == '0 || age_q[i] > old_age) begin
                old_oh    = '0;
                old_oh[i] = 1'b1;
                old_age   = age_q[i];
            end
        end
        if (hit_oh != '0)
            sel_oh = hit_oh;
        else if (idle_oh != '0)
            sel_oh = idle_oh;
        else
            sel_oh = old_oh;
    end

    always_comb begin
        ev_state_d  = ev_state_q;
        ev_ready_d  = ev_ready_q;
        ev_d        = ev_q;
        steal_d     = 1'b0;
        age_d       = age_q;
        cmd_load    = '0;
        cmd_retrig  = '0;
        cmd_release = '0;
        if (ev_state_q == EV_ACCEPT) begin
            ev_ready_d = 1'b1;
            if (evValid && ev_ready_q) begin
                ev_d.noteOn   = evNoteOn;
                ev_d.tuneWord = evTuneWord;
                ev_d.volume   = evVolume;
                ev_state_d    = EV_PROCESS;
                ev_ready_d    = 1'b0;
            end
        end else begin
            ev_state_d = EV_ACCEPT;
            ev_ready_d = 1'b1;
            if (note_on) begin
                cmd_retrig = hit_oh;
                cmd_load   = (hit_oh == '0) ? sel_oh : '0;
                steal_d    = (hit_oh == '0) && (idle_oh == '0);
                for (int i = 0; i < NUM_TRACKS; i++) begin
                    if (sel_oh[i])
                        age_d[i] = '0;
                    else if (v_busy[i] && age_q[i] != AGE_MAX)
                        age_d[i] = age_q[i] + AGE_W'(1);
                end
            end else begin
                cmd_release = rel_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_state_q <= EV_ACCEPT;
            ev_ready_q <= 1'b0;
            ev_q       <= '0;
            steal_q    <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < NUM_TRACKS; i++)
                age_q[i] <= '0;
        end else begin
            ev_state_q <= ev_state_d;
            ev_ready_q <= ev_ready_d;
            ev_q       <= ev_d;
            steal_q    <= steal_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < NUM_TRACKS; i++)
                age_q[i] <= age_d[i];
        end
    end

    voice_envelope #(
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) u_voice [NUM_TRACKS-1:0] (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .cmd_load   (cmd_load),
        .cmd_retrig (cmd_retrig),
        .cmd_release(cmd_release),
        .cmd_tune   (ev_tune),
        .cmd_target (ev_vol),
        .state_o    (state_flat),
        .packet_o   (notePackets)
    );

    assign voiceBusy  = v_busy;
    assign evReady    = ev_ready_q;
    assign stealPulse = steal_q;

endmodule
